// File: rtl/sprite_motion_pkg.sv
// Shared types and helpers for the sprite motion engine.
// Fixed-point values are signed 32-bit with FRAC_BITS fractional bits.
package sprite_motion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  typedef logic signed [31:0] fx_t;

  localparam int SIDE_TOP    = 3;
  localparam int SIDE_BOTTOM = 2;
  localparam int SIDE_LEFT   = 1;
  localparam int SIDE_RIGHT  = 0;

  function automatic fx_t abs_fx(input fx_t v);
    fx_t r;
    if (v < 32'sd0) r = -v;
    else            r = v;
    return r;
  endfunction

  function automatic fx_t sat_fx(input fx_t v, input fx_t lim);
    fx_t r;
    if (v > lim)       r = lim;
    else if (v < -lim) r = -lim;
    else               r = v;
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis_integrator.sv
// One motion axis: speed reflect/accelerate/saturate in the speed phase,
// position integrate and clamp to [0, limit] in the position phase.
module axis_integrator
  import sprite_motion_pkg::*;
#(
  parameter int FRAC_BITS  = 6,
  parameter int LIMIT_PIX  = 608,
  parameter int ACCEL      = 0,
  parameter int MAX_SPEED  = 512,
  parameter int INIT_PIX   = 0,
  parameter int INIT_SPEED = 0
) (
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  logic spd_phase,
  input  logic pos_phase,
  input  logic negate,
  input  logic side_lo,
  input  logic side_hi,
  output fx_t  pos,
  output logic clamp_lo,
  output logic clamp_hi
);

  localparam fx_t POS_MAX  = fx_t'(LIMIT_PIX) <<< FRAC_BITS;
  localparam fx_t POS_INIT = fx_t'(INIT_PIX) <<< FRAC_BITS;
  localparam fx_t SPD_INIT = fx_t'(INIT_SPEED);
  localparam fx_t SPD_ACC  = fx_t'(ACCEL);
  localparam fx_t SPD_MAX  = fx_t'(MAX_SPEED);

  fx_t  pos_r, spd_r;
  fx_t  spd_acc_s, spd_next_s, pos_sum_s, pos_next_s;
  logic hit_lo_s, hit_hi_s, under_s, over_s;
  logic clamp_lo_r, clamp_hi_r;

  // Speed phase: toggle, gravity, wall sign forcing, saturation
  always_comb begin
    spd_acc_s = spd_r;
    if (negate) spd_acc_s = -spd_r + SPD_ACC;
    else        spd_acc_s = spd_r + SPD_ACC;
    hit_lo_s = side_lo || ((pos_r == 32'sd0) && (spd_acc_s < 32'sd0));
    hit_hi_s = side_hi || ((pos_r == POS_MAX) && (spd_acc_s > 32'sd0));
    if (hit_lo_s && hit_hi_s) spd_next_s = sat_fx(-spd_acc_s, SPD_MAX);
    else if (hit_lo_s)        spd_next_s = sat_fx(abs_fx(spd_acc_s), SPD_MAX);
    else if (hit_hi_s)        spd_next_s = sat_fx(-abs_fx(spd_acc_s), SPD_MAX);
    else                      spd_next_s = sat_fx(spd_acc_s, SPD_MAX);
  end

  // Position phase: integrate and clamp into the visible range
  always_comb begin
    pos_sum_s = pos_r + spd_r;
    under_s   = pos_sum_s < 32'sd0;
    over_s    = pos_sum_s > POS_MAX;
    if (under_s)     pos_next_s = 32'sd0;
    else if (over_s) pos_next_s = POS_MAX;
    else             pos_next_s = pos_sum_s;
  end

  // Axis state registers; clamp flags are single-cycle pulses
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_r      <= POS_INIT;
      spd_r      <= 32'sd0;
      clamp_lo_r <= 1'b0;
      clamp_hi_r <= 1'b0;
    end else if (load) begin
      pos_r      <= POS_INIT;
      spd_r      <= SPD_INIT;
      clamp_lo_r <= 1'b0;
      clamp_hi_r <= 1'b0;
    end else begin
      if (spd_phase) spd_r <= spd_next_s;
      if (pos_phase) begin
        pos_r      <= pos_next_s;
        clamp_lo_r <= under_s;
        clamp_hi_r <= over_s;
      end else begin
        clamp_lo_r <= 1'b0;
        clamp_hi_r <= 1'b0;
      end
    end
  end

  assign pos      = pos_r;
  assign clamp_lo = clamp_lo_r;
  assign clamp_hi = clamp_hi_r;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion engine: launch/pause FSM, event latching and a
// two-stage speed/position update feeding the renderer's top-left pixel.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int FRAC_BITS       = 6,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int OBJ_W           = 32,
  parameter int OBJ_H           = 32,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 30,
  parameter int INITIAL_Y_SPEED = 20,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_SPEED       = 512
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        launch,
  input  logic        pause,
  input  logic        toggleY,
  input  logic        collision,
  input  logic [3:0]  hitSide,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        moving,
  output logic [3:0]  borderHit,
  output logic        frameDone
);

  state_t     state_r, state_s;
  logic       launch_d_r, toggle_d_r;
  logic [3:0] pend_side_r;
  logic       pend_toggle_r;
  logic       pos_phase_r, frame_done_r, moving_r;
  logic       launch_rise_s, toggle_rise_s, load_s, spd_phase_s, neg_s;
  logic [3:0] side_s;
  fx_t        pos_x_s, pos_y_s;
  logic       x_lo_s, x_hi_s, y_lo_s, y_hi_s;

  assign launch_rise_s = launch & ~launch_d_r;
  assign toggle_rise_s = toggleY & ~toggle_d_r;
  assign load_s        = (state_r == IDLE) && launch_rise_s;
  // A new frame is refused while the previous update is still in flight
  assign spd_phase_s   = startOfFrame && (state_r == RUN) && !pause &&
                         !pos_phase_r && !frame_done_r;
  assign side_s        = pend_side_r | (collision ? hitSide : 4'b0000);
  assign neg_s         = pend_toggle_r | toggle_rise_s;

  // Next-state logic of the launch/pause FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (launch_rise_s) state_s = RUN;    else state_s = IDLE;
      RUN:     if (pause)         state_s = PAUSED; else state_s = RUN;
      PAUSED:  if (!pause)        state_s = RUN;    else state_s = PAUSED;
      default: state_s = IDLE;
    endcase
  end

  // FSM, edge detectors, sticky event flags and pipeline strobes
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= IDLE;
      launch_d_r    <= 1'b0;
      toggle_d_r    <= 1'b0;
      pend_side_r   <= 4'b0000;
      pend_toggle_r <= 1'b0;
      pos_phase_r   <= 1'b0;
      frame_done_r  <= 1'b0;
      moving_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      launch_d_r   <= launch;
      toggle_d_r   <= toggleY;
      pos_phase_r  <= spd_phase_s;
      frame_done_r <= pos_phase_r;
      moving_r     <= (state_s == RUN);
      if ((state_r == IDLE) || spd_phase_s) begin
        pend_side_r   <= 4'b0000;
        pend_toggle_r <= 1'b0;
      end else begin
        pend_side_r   <= side_s;
        pend_toggle_r <= neg_s;
      end
    end
  end

  axis_integrator #(
    .FRAC_BITS(FRAC_BITS), .LIMIT_PIX(SCREEN_W - OBJ_W), .ACCEL(0),
    .MAX_SPEED(MAX_SPEED), .INIT_PIX(INITIAL_X), .INIT_SPEED(INITIAL_X_SPEED)
  ) u_axis_x (
    .clk(clk), .resetN(resetN), .load(load_s), .spd_phase(spd_phase_s),
    .pos_phase(pos_phase_r), .negate(1'b0),
    .side_lo(side_s[SIDE_LEFT]), .side_hi(side_s[SIDE_RIGHT]),
    .pos(pos_x_s), .clamp_lo(x_lo_s), .clamp_hi(x_hi_s)
  );

  axis_integrator #(
    .FRAC_BITS(FRAC_BITS), .LIMIT_PIX(SCREEN_H - OBJ_H), .ACCEL(Y_ACCEL),
    .MAX_SPEED(MAX_SPEED), .INIT_PIX(INITIAL_Y), .INIT_SPEED(INITIAL_Y_SPEED)
  ) u_axis_y (
    .clk(clk), .resetN(resetN), .load(load_s), .spd_phase(spd_phase_s),
    .pos_phase(pos_phase_r), .negate(neg_s),
    .side_lo(side_s[SIDE_TOP]), .side_hi(side_s[SIDE_BOTTOM]),
    .pos(pos_y_s), .clamp_lo(y_lo_s), .clamp_hi(y_hi_s)
  );

  assign topLeftX  = 11'(pos_x_s >>> FRAC_BITS);
  assign topLeftY  = 11'(pos_y_s >>> FRAC_BITS);
  assign moving    = moving_r;
  assign borderHit = {y_lo_s, y_hi_s, x_lo_s, x_hi_s};
  assign frameDone = frame_done_r;

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Parametrised per-frame motion engine for one on-screen sprite in the VGA path.
- Holds position and velocity in signed fixed point and applies gravity and speed saturation.
- Reflects velocity on screen borders and on collision reports from the drawing logic.
- Has a launch/pause state machine; drives the sprite's top-left pixel coordinate to the renderer.

Parameters:
FRAC_BITS, 6, fractional bits of position/speed (scale 2^FRAC_BITS)
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
OBJ_W, 32, sprite width in pixels
OBJ_H, 32, sprite height in pixels
INITIAL_X, 280, reset/idle X pixel
INITIAL_Y, 185, reset/idle Y pixel
INITIAL_X_SPEED, 30, launch X speed (subpixels/frame, signed)
INITIAL_Y_SPEED, 20, launch Y speed (subpixels/frame, signed, positive = down)
Y_ACCEL, 1, added to Y speed every running frame (gravity)
MAX_SPEED, 512, magnitude limit of each speed component

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clock pulse per frame
launch  in  1  level; rising edge starts motion from IDLE
pause  in  1  level; high freezes motion
toggleY  in  1  level; rising edge negates Y speed
collision  in  1  one-clock pulse: sprite overlapped an obstacle
hitSide  in  4  valid with collision: {top,bottom,left,right} side of sprite hit
topLeftX  out  11  sprite X pixel
topLeftY  out  11  sprite Y pixel
moving  out  1  high in RUN
borderHit  out  4  one-clock pulse {top,bottom,left,right}: border clamp occurred this frame
frameDone  out  1  one-clock pulse: position update committed

Behaviour:
- Reset is asynchronous, active-low, on resetN; clock is clk.
- Reset values:
  - state IDLE.
  - posX = INITIAL_X<<FRAC_BITS, posY = INITIAL_Y<<FRAC_BITS.
  - speeds 0; pending flags 0.
  - Outputs: topLeftX=INITIAL_X, topLeftY=INITIAL_Y, moving=0, borderHit=0, frameDone=0.
- Internal arithmetic:
  - 32-bit signed.
  - topLeftX = posX>>>FRAC_BITS (arithmetic shift, never negative thanks to clamping); likewise Y.
  - Shift by FRAC_BITS replaces division.
- Limits: XMAX = (SCREEN_W-OBJ_W)<<FRAC_BITS; YMAX = (SCREEN_H-OBJ_H)<<FRAC_BITS; minimum 0.
- States: IDLE, RUN, PAUSED.
  - IDLE -> RUN on launch rising edge: load speeds with INITIAL_*_SPEED and position with initial values.
  - RUN -> PAUSED when pause=1 at any clock.
  - PAUSED -> RUN when pause=0.
  - An update pipeline already in flight completes even if pause rises.
- Pending flags, each sticky until consumed by the speed phase:
  - In RUN and PAUSED: collision ORs hitSide into pendSide; toggleY rising edge sets pendToggle.
  - Ignored and cleared in IDLE.
- Update pipeline, triggered by startOfFrame in RUN only (ignored in IDLE and PAUSED). With startOfFrame at cycle T:
  - T+1 speed phase, applied in this order:
    1. If pendToggle: Yspd = -Yspd.
    2. Yspd += Y_ACCEL.
    3. Wall reflection as sign forcing (bounce always points away from the wall):
       - top (pendSide[3] or posY==0 with Yspd<0): Yspd = +|Yspd|.
       - bottom (pendSide[2] or posY==YMAX with Yspd>0): Yspd = -|Yspd|.
       - left/right analogously on Xspd.
       - If both opposite sides are set in one frame, speed is negated.
    4. Saturate each component to ±MAX_SPEED.
    5. Clear the pending flags.
  - T+2 position phase:
    - posX += Xspd, posY += Yspd.
    - Any result <0 clamps to 0; any result >max clamps to max.
    - Each clamp pulses the matching borderHit bit.
    - frameDone pulses.
  - Latency from startOfFrame to outputs: 2 clocks.
  - A startOfFrame arriving during T+1/T+2 is ignored (never happens at VGA rates).
- Event collisions:
  - A collision or toggle landing at T+1 is consumed in that frame.
  - One landing at T+2 is kept for the next frame.
- Reset mid-pipeline: everything returns to reset values immediately; no partial update survives.

Decomposition:
- Shared package sprite_motion_pkg holds:
  - typedef state_t {IDLE,RUN,PAUSED}
  - typedef fx_t = signed 32-bit
  - side index constants SIDE_TOP=3, SIDE_BOTTOM=2, SIDE_LEFT=1, SIDE_RIGHT=0
- One natural sub-module, axis_integrator: one instance per axis.
  - Handles speed reflect/saturate and position clamp for a single axis.
  - Parametrised by limit and acceleration (X instance uses accel 0).
  - Top level holds the FSM, edge detectors and pending flags.

Test Plan:
- Reset, then 3 startOfFrame without launch -> topLeftX=280, topLeftY=185, moving=0, frameDone never pulses.
- Launch, then 3 frames -> posX=17920+90=18010 (X=281); Y speeds 21,22,23 give posY=11840+66=11906 (Y=186); frameDone 2 clocks after each startOfFrame.
- INITIAL_X=607, INITIAL_X_SPEED=128, launch, 1 frame -> posX clamps 38976->38912 (X=608), borderHit=0001. Next frame Xspd=-128 -> X=606.
- Collision with hitSide=0100 while Yspd=+25 (bottom) plus toggleY edge in same frame -> Yspd ends negative (-|(-25)+1|=-24); pending cleared.
- pause high across 4 startOfFrame pulses -> position frozen, moving=0. Collision during pause is applied on the first frame after pause drops.
- Assert resetN low at T+1 of an update -> outputs return to 280/185, IDLE, no frameDone; Y_ACCEL=600 run -> Yspd saturates at 512.
